// File: rtl/irrigation_sequencer_if.sv
// Request/valve/status bundle between the irrigation controllers and the pump sequencer.
// With IRRIGATION_SEQ_ALARM_LATCH_EN defined the bundle also carries alarm_ack.
interface irrigation_sequencer_if;
    logic       enable;
    logic       splinker_request;
    logic       dripper_request;
    logic       water_critical;
    logic       sensor_error;
`ifdef IRRIGATION_SEQ_ALARM_LATCH_EN
    logic       alarm_ack;
`endif
    logic       splinker_valve;
    logic       dripper_valve;
    logic       pump_on;
    logic       alarm;
    logic [2:0] state;

`ifdef IRRIGATION_SEQ_ALARM_LATCH_EN
    modport master (
        output enable, splinker_request, dripper_request, water_critical, sensor_error, alarm_ack,
        input  splinker_valve, dripper_valve, pump_on, alarm, state
    );
    modport slave (
        input  enable, splinker_request, dripper_request, water_critical, sensor_error, alarm_ack,
        output splinker_valve, dripper_valve, pump_on, alarm, state
    );
`else
    modport master (
        output enable, splinker_request, dripper_request, water_critical, sensor_error,
        input  splinker_valve, dripper_valve, pump_on, alarm, state
    );
    modport slave (
        input  enable, splinker_request, dripper_request, water_critical, sensor_error,
        output splinker_valve, dripper_valve, pump_on, alarm, state
    );
`endif
endinterface

// File: rtl/irrigation_sequencer.sv
// Shares one pump between sprinkler and dripper with min/max on-time, dead time and interlock.
// Optional macro IRRIGATION_SEQ_ALARM_LATCH_EN: alarm latches until alarm_ack with interlock clear.
module irrigation_sequencer #(
    parameter int MIN_ON_CYCLES = 8,
    parameter int MAX_ON_CYCLES = 64,
    parameter int DEAD_CYCLES   = 4,
    parameter int CNT_W         = 7
) (
    input  logic                  clock,
    input  logic                  reset,
    irrigation_sequencer_if.slave bus
);

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_RUN_S   = 3'd1,
        ST_RUN_D   = 3'd2,
        ST_DEAD    = 3'd3,
        ST_LOCKOUT = 3'd4
    } state_t;

    state_t             state_r;
    state_t             state_s;
    logic [CNT_W-1:0]   cnt_r;
    logic [CNT_W-1:0]   cnt_s;
    logic               last_drip_r;
    logic               last_drip_s;
    logic               interlock_s;
    logic               served_req_s;
    logic               splinker_valve_r;
    logic               dripper_valve_r;
    logic               pump_on_r;
    logic               alarm_r;
    logic               splinker_valve_s;
    logic               dripper_valve_s;
    logic               pump_on_s;
    logic               alarm_s;

    assign interlock_s = bus.water_critical | bus.sensor_error;

    // State, run/dead counter and fairness memory registers
    always_ff @(posedge clock) begin
        if (reset) begin
            state_r     <= ST_IDLE;
            cnt_r       <= {CNT_W{1'b0}};
            last_drip_r <= 1'b1;
        end else begin
            state_r     <= state_s;
            cnt_r       <= cnt_s;
            last_drip_r <= last_drip_s;
        end
    end

    // Next-state logic; the interlock overrides every state including min-on
    always_comb begin
        state_s      = state_r;
        cnt_s        = cnt_r;
        last_drip_s  = last_drip_r;
        served_req_s = 1'b0;
        if (interlock_s) begin
            state_s = ST_LOCKOUT;
            cnt_s   = {CNT_W{1'b0}};
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (bus.enable && (bus.splinker_request || bus.dripper_request)) begin
                        // With both pending, serve whoever was not served last
                        if (bus.splinker_request && bus.dripper_request) begin
                            last_drip_s = ~last_drip_r;
                        end else begin
                            last_drip_s = bus.dripper_request;
                        end
                        state_s = last_drip_s ? ST_RUN_D : ST_RUN_S;
                        cnt_s   = {CNT_W{1'b0}};
                    end else begin
                        state_s = ST_IDLE;
                    end
                end
                ST_RUN_S, ST_RUN_D: begin
                    served_req_s = bus.enable &
                                   ((state_r == ST_RUN_S) ? bus.splinker_request : bus.dripper_request);
                    if (cnt_r == CNT_W'(MAX_ON_CYCLES - 1)) begin
                        state_s = ST_DEAD;
                        cnt_s   = {CNT_W{1'b0}};
                    end else if (!served_req_s && (cnt_r >= CNT_W'(MIN_ON_CYCLES - 1))) begin
                        state_s = ST_DEAD;
                        cnt_s   = {CNT_W{1'b0}};
                    end else begin
                        cnt_s   = cnt_r + CNT_W'(1);
                    end
                end
                ST_DEAD: begin
                    if (cnt_r == CNT_W'(DEAD_CYCLES - 1)) begin
                        state_s = ST_IDLE;
                        cnt_s   = {CNT_W{1'b0}};
                    end else begin
                        cnt_s   = cnt_r + CNT_W'(1);
                    end
                end
                ST_LOCKOUT: begin
                    state_s = ST_DEAD;
                    cnt_s   = {CNT_W{1'b0}};
                end
                default: begin
                    state_s = ST_IDLE;
                    cnt_s   = {CNT_W{1'b0}};
                end
            endcase
        end
    end

    // Output decode from the next state so the registered outputs track the state register
    always_comb begin
        splinker_valve_s = (state_s == ST_RUN_S);
        dripper_valve_s  = (state_s == ST_RUN_D);
        pump_on_s        = (state_s == ST_RUN_S) || (state_s == ST_RUN_D);
`ifdef IRRIGATION_SEQ_ALARM_LATCH_EN
        if (state_s == ST_LOCKOUT) begin
            alarm_s = 1'b1;
        end else if (bus.alarm_ack && !interlock_s) begin
            alarm_s = 1'b0;
        end else begin
            alarm_s = alarm_r;
        end
`else
        alarm_s = (state_s == ST_LOCKOUT);
`endif
    end

    // Output registers
    always_ff @(posedge clock) begin
        if (reset) begin
            splinker_valve_r <= 1'b0;
            dripper_valve_r  <= 1'b0;
            pump_on_r        <= 1'b0;
            alarm_r          <= 1'b0;
        end else begin
            splinker_valve_r <= splinker_valve_s;
            dripper_valve_r  <= dripper_valve_s;
            pump_on_r        <= pump_on_s;
            alarm_r          <= alarm_s;
        end
    end

    assign bus.splinker_valve = splinker_valve_r;
    assign bus.dripper_valve  = dripper_valve_r;
    assign bus.pump_on        = pump_on_r;
    assign bus.alarm          = alarm_r;
    assign bus.state          = state_r;

endmodule

// File: tb/tb_irrigation_sequencer.sv
// Randomized/directed bench for irrigation_sequencer against a cycle-level behavioural model.
module tb_irrigation_sequencer;

    localparam int MIN_ON = 8;
    localparam int MAX_ON = 64;
    localparam int DEAD   = 4;

    logic clock;
    logic reset;
    int   n_cmp;
    int   n_bad;

    irrigation_sequencer_if bus ();

    irrigation_sequencer #(
        .MIN_ON_CYCLES(MIN_ON), .MAX_ON_CYCLES(MAX_ON), .DEAD_CYCLES(DEAD), .CNT_W(7)
    ) dut (
        .clock(clock),
        .reset(reset),
        .bus  (bus)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Behavioural model: who is being served, for how long, rest remaining, lockout, fairness
    int   m_who;     // 0 none, 1 sprinkler, 2 dripper
    int   m_age;
    int   m_rest;
    bit   m_locked;
    int   m_last;
    bit   m_latch;

    task automatic model_step();
        bit ilk;
        bit want;
        int pick;
        ilk = bus.water_critical | bus.sensor_error;
        if (reset) begin
            m_who = 0; m_age = 0; m_rest = 0; m_locked = 0; m_last = 2; m_latch = 0;
        end else begin
            if (ilk) begin
                m_locked = 1; m_who = 0; m_rest = 0;
            end else if (m_locked) begin
                m_locked = 0; m_rest = DEAD;
            end else if (m_who != 0) begin
                m_age++;
                want = bus.enable & ((m_who == 1) ? bus.splinker_request : bus.dripper_request);
                if (m_age == MAX_ON || (!want && m_age >= MIN_ON)) begin
                    m_who = 0; m_rest = DEAD;
                end
            end else if (m_rest > 0) begin
                m_rest--;
            end else if (bus.enable) begin
                pick = 0;
                if (bus.splinker_request && bus.dripper_request) pick = 3 - m_last;
                else if (bus.splinker_request) pick = 1;
                else if (bus.dripper_request) pick = 2;
                if (pick != 0) begin
                    m_who = pick; m_age = 0; m_last = pick;
                end
            end
`ifdef IRRIGATION_SEQ_ALARM_LATCH_EN
            if (ilk) m_latch = 1;
            else if (bus.alarm_ack) m_latch = 0;
`endif
        end
    endtask

    function automatic logic [6:0] expected();
        logic [2:0] st;
        logic       al;
        st = m_locked ? 3'd4 : (m_who == 1) ? 3'd1 : (m_who == 2) ? 3'd2 : (m_rest != 0) ? 3'd3 : 3'd0;
`ifdef IRRIGATION_SEQ_ALARM_LATCH_EN
        al = m_latch;
`else
        al = m_locked;
`endif
        return {(m_who == 1), (m_who == 2), (m_who != 0), al, st};
    endfunction

    function automatic logic [6:0] observed();
        return {bus.splinker_valve, bus.dripper_valve, bus.pump_on, bus.alarm, bus.state};
    endfunction

    task automatic tick();
        @(posedge clock);
        model_step();
        #1;
    endtask

    task automatic set_inputs(input bit en, input bit sr, input bit dr, input bit wc, input bit se);
        bus.enable = en; bus.splinker_request = sr; bus.dripper_request = dr;
        bus.water_critical = wc; bus.sensor_error = se;
`ifdef IRRIGATION_SEQ_ALARM_LATCH_EN
        bus.alarm_ack = 1'b0;
`endif
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        set_inputs(1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
        reset = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            n_cmp++;
            if (observed() !== 7'b0) begin
                n_bad++;
                $display("FAIL reset cyc=%0d got=%b want=%b", i, observed(), 7'b0);
            end
        end
        reset = 1'b0;
        set_inputs(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic test_min_on_pulse();
        int open_n;
        int dead_n;
        open_n = 0; dead_n = 0;
        set_inputs(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        do_reset();
        bus.splinker_request = 1'b1;
        for (int i = 0; i < 16; i++) begin
            tick();
            bus.splinker_request = 1'b0;
            if (bus.splinker_valve && bus.pump_on) open_n++;
            if (bus.state == 3'd3) dead_n++;
            n_cmp++;
            if (observed() !== expected()) begin
                n_bad++;
                $display("FAIL min_on_pulse cyc=%0d got=%b want=%b", i, observed(), expected());
            end
        end
        n_cmp++;
        if (open_n !== MIN_ON || dead_n !== DEAD || bus.state !== 3'd0) begin
            n_bad++;
            $display("FAIL min_on_counts got open=%0d dead=%0d st=%0d want open=%0d dead=%0d st=0",
                     open_n, dead_n, bus.state, MIN_ON, DEAD);
        end
    endtask

    task automatic test_max_on_fairness();
        int s_n;
        int d_n;
        s_n = 0; d_n = 0;
        set_inputs(1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
        do_reset();
        for (int i = 0; i < 2 * (MAX_ON + DEAD + 1) + 5; i++) begin
            tick();
            if (bus.splinker_valve) s_n++;
            if (bus.dripper_valve) d_n++;
            n_cmp++;
            if (observed() !== expected() || (bus.splinker_valve && bus.dripper_valve)) begin
                n_bad++;
                $display("FAIL max_on_fairness cyc=%0d got=%b want=%b", i, observed(), expected());
            end
        end
        n_cmp++;
        if (d_n !== MAX_ON || s_n !== MAX_ON + 5) begin
            n_bad++;
            $display("FAIL fairness_counts got s=%0d d=%0d want s=%0d d=%0d", s_n, d_n, MAX_ON + 5, MAX_ON);
        end
    endtask

    task automatic test_interlock();
        set_inputs(1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
        do_reset();
        for (int i = 0; i < 30; i++) begin
            if (i == 2) bus.water_critical = 1'b1;
            if (i == 12) bus.water_critical = 1'b0;
            tick();
            n_cmp++;
            if (observed() !== expected()) begin
                n_bad++;
                $display("FAIL interlock cyc=%0d got=%b want=%b", i, observed(), expected());
            end
            if (i == 2) begin
                n_cmp++;
                if (bus.dripper_valve !== 1'b0 || bus.pump_on !== 1'b0 || bus.state !== 3'd4) begin
                    n_bad++;
                    $display("FAIL interlock_close got dv=%b pump=%b st=%0d want 0 0 4",
                             bus.dripper_valve, bus.pump_on, bus.state);
                end
            end
        end
    endtask

    task automatic test_reset_mid_run();
        set_inputs(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        do_reset();
        for (int i = 0; i < 5; i++) tick();
        bus.dripper_request = 1'b1;
        reset = 1'b1;
        tick();
        reset = 1'b0;
        n_cmp++;
        if (observed() !== 7'b0) begin
            n_bad++;
            $display("FAIL reset_mid_run got=%b want=%b", observed(), 7'b0);
        end
        tick();
        n_cmp++;
        if (bus.splinker_valve !== 1'b1 || bus.dripper_valve !== 1'b0 || observed() !== expected()) begin
            n_bad++;
            $display("FAIL reset_first_grant got=%b want=%b", observed(), expected());
        end
    endtask

    task automatic test_enable();
        set_inputs(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        do_reset();
        for (int i = 0; i < 20; i++) begin
            tick();
            n_cmp++;
            if (bus.pump_on !== 1'b0 || bus.dripper_valve !== 1'b0 || observed() !== expected()) begin
                n_bad++;
                $display("FAIL enable_low cyc=%0d got=%b want=%b", i, observed(), expected());
            end
        end
        bus.enable = 1'b1;
        tick();
        n_cmp++;
        if (bus.dripper_valve !== 1'b1 || observed() !== expected()) begin
            n_bad++;
            $display("FAIL enable_grant got=%b want=%b", observed(), expected());
        end
    endtask

    task automatic test_alarm();
        set_inputs(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        do_reset();
        for (int i = 0; i < 24; i++) begin
            bus.sensor_error = (i == 3 || i == 4);
`ifdef IRRIGATION_SEQ_ALARM_LATCH_EN
            bus.alarm_ack = (i == 16);
`endif
            tick();
            n_cmp++;
            if (observed() !== expected()) begin
                n_bad++;
                $display("FAIL alarm cyc=%0d got=%b want=%b", i, observed(), expected());
            end
        end
    endtask

    task automatic test_random();
        bit sr;
        bit dr;
        bit wc;
        bit se;
        sr = 0; dr = 0; wc = 0; se = 0;
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 7) == 0) sr = ~sr;
            if ($urandom_range(0, 7) == 0) dr = ~dr;
            if (wc ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 59) == 0)) wc = ~wc;
            if (se ? ($urandom_range(0, 1) == 0) : ($urandom_range(0, 99) == 0)) se = ~se;
            set_inputs($urandom_range(0, 9) != 0, sr, dr, wc, se);
`ifdef IRRIGATION_SEQ_ALARM_LATCH_EN
            bus.alarm_ack = ($urandom_range(0, 15) == 0);
`endif
            reset = ($urandom_range(0, 399) == 0);
            tick();
            n_cmp++;
            if (observed() !== expected() || (bus.splinker_valve && bus.dripper_valve) ||
                (bus.pump_on !== (bus.splinker_valve ^ bus.dripper_valve))) begin
                n_bad++;
                $display("FAIL random cyc=%0d got=%b want=%b", i, observed(), expected());
            end
        end
        reset = 1'b0;
    endtask

    initial begin
        n_cmp = 0;
        n_bad = 0;
        reset = 1'b0;
        m_who = 0; m_age = 0; m_rest = 0; m_locked = 0; m_last = 2; m_latch = 0;
        set_inputs(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        test_reset();
        test_min_on_pulse();
        test_max_on_fairness();
        test_interlock();
        test_reset_mid_run();
        test_enable();
        test_alarm();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
